// File: rtl/memory_responder.sv
// Fixed-latency single-port memory responder: accepts one CPU read or write
// at a time and answers with a one-cycle pulse LATENCY cycles after acceptance.
module memory_responder #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  input  logic [15:0] data_wr,
  output logic [15:0] data_rd,
  output logic        inputReady,
  output logic        ackOutput,
  output logic        busy,
  output logic        protocol_err
);

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [3:0]             cnt_r;
  logic                   op_write_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [15:0]            wdata_r;
  logic [15:0]            mem_r [0:DEPTH-1];

  logic                   accept_s;
  logic                   clash_s;
  logic                   op_next_s;
  logic [ADDR_BITS-1:0]   addr_next_s;
  logic [15:0]            wdata_next_s;
  logic                   busy_s;
  logic                   rdy_s;
  logic                   ack_s;
  logic                   err_s;
  logic [15:0]            rdata_s;
  logic                   addr_hi_unused_s;

  assign accept_s     = (state_r == IDLE) && (readM ^ writeM);
  assign clash_s      = (state_r == IDLE) && readM && writeM;
  assign addr_hi_unused_s = ^address[15:ADDR_BITS];

  // Request fields as they will be after this edge; lets a LATENCY=1 build respond from the accepting edge.
  assign op_next_s    = accept_s ? writeM : op_write_r;
  assign addr_next_s  = accept_s ? address[ADDR_BITS-1:0] : addr_r;
  assign wdata_next_s = accept_s ? data_wr : wdata_r;

  // State register, countdown and request latches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      op_write_r <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r      <= LAT_M1;
        op_write_r <= writeM;
        addr_r     <= address[ADDR_BITS-1:0];
        wdata_r    <= data_wr;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state logic; WAIT leaves on the edge that takes the counter to zero
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it
  always_comb begin
    busy_s  = 1'b0;
    rdy_s   = 1'b0;
    ack_s   = 1'b0;
    err_s   = clash_s;
    rdata_s = data_rd;
    if (state_s != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    if (state_s == RESP) begin
      rdy_s = ~op_next_s;
      ack_s = op_next_s;
    end else begin
      rdy_s = 1'b0;
      ack_s = 1'b0;
    end
    if (rdy_s) begin
      rdata_s = mem_r[addr_next_s];
    end else begin
      rdata_s = data_rd;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_rd      <= 16'h0000;
      inputReady   <= 1'b0;
      ackOutput    <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      data_rd      <= rdata_s;
      inputReady   <= rdy_s;
      ackOutput    <= ack_s;
      busy         <= busy_s;
      protocol_err <= err_s;
    end
  end

  // Storage is never cleared; a write commits on the edge entering RESP unless reset wins
  always_ff @(posedge clk) begin
    if (reset_n && ack_s) begin
      mem_r[addr_next_s] <= wdata_next_s;
    end
  end

endmodule
